// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with 16x oversampling and 3-sample majority vote
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] Data,
  output logic       rx_done,
  output logic       frame_error,
  output logic       rx_busy
);
  localparam int DIV0 = CLK_FREQ / (9600 * 16);
  localparam int DIV1 = CLK_FREQ / (19200 * 16);
  localparam int DIV2 = CLK_FREQ / (38400 * 16);
  localparam int DIV3 = CLK_FREQ / (57600 * 16);
  localparam int DIV4 = CLK_FREQ / (115200 * 16);
  localparam int DW = $clog2(DIV0 + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic s1, s2, s3;
  logic [2:0] baud_q;
  logic [DW-1:0] div_cnt, div_max;
  logic [3:0] smp_cnt, bit_cnt;
  logic [1:0] votes;
  logic [7:0] shreg;
  logic start_edge, smp_tick, mid_tick, end_tick, vote;
  assign start_edge = !s2 && s3;
  assign smp_tick = state != IDLE && div_cnt == div_max;
  assign mid_tick = smp_tick && smp_cnt == 4'd8;
  assign end_tick = smp_tick && smp_cnt == 4'd15;
  assign vote = (votes[0] & votes[1]) | (votes[0] & s2) | (votes[1] & s2);
  always_comb
    div_max = baud_q == 3'd1 ? DW'(DIV1 - 1) :
              baud_q == 3'd2 ? DW'(DIV2 - 1) :
              baud_q == 3'd3 ? DW'(DIV3 - 1) :
              baud_q == 3'd4 ? DW'(DIV4 - 1) : DW'(DIV0 - 1);
  // s3 holds the previous synchronised level for start-edge detection
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) {s1, s2, s3} <= 3'b111;
    else {s1, s2, s3} <= {uart_rx, s1, s2};
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_edge) state_nx = START;
      START:   if (mid_tick && vote) state_nx = IDLE;
               else if (end_tick) state_nx = DATA;
      DATA:    if (end_tick && bit_cnt == 4'd8) state_nx = STOP;
      STOP:    if (mid_tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb rx_busy = state != IDLE;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      baud_q      <= '0;
      div_cnt     <= '0;
      smp_cnt     <= '0;
      bit_cnt     <= '0;
      votes       <= '0;
      shreg       <= '0;
      Data        <= '0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_done     <= state == STOP && mid_tick && vote;
      frame_error <= state == STOP && mid_tick && !vote;
      if (state == IDLE) begin
        div_cnt <= '0;
        smp_cnt <= '0;
        bit_cnt <= '0;
        if (start_edge) baud_q <= baud_set;
      end else begin
        div_cnt <= smp_tick ? '0 : div_cnt + 1'b1;
        if (smp_tick) smp_cnt <= smp_cnt + 1'b1;
        if (smp_tick && smp_cnt == 4'd6) votes[0] <= s2;
        if (smp_tick && smp_cnt == 4'd7) votes[1] <= s2;
        if (end_tick) bit_cnt <= bit_cnt + 1'b1;
        if (state == DATA && mid_tick) shreg <= {vote, shreg[7:1]};
        if (state == STOP && mid_tick && vote) Data <= shreg;
      end
    end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed frame vectors plus glitch, spike and reset sequences
module tb_uart_byte_rx;
  localparam int CLK_FREQ = 10_000_000;
  logic Clk = 1'b0, Reset_n = 1'b0, uart_rx = 1'b1;
  logic [2:0] baud_set = 3'd4;
  logic [7:0] Data;
  logic rx_done, frame_error, rx_busy;
  int vectors = 0, miscompares = 0;
  int done_cnt = 0, ferr_cnt = 0, d0, f0;
  logic prev_strobe = 1'b0;
  typedef struct {
    logic [2:0] baud, mid;
    int pct;
    logic [7:0] b;
    logic stop;
    int gap, exp_done, exp_ferr;
    logic [7:0] exp_data;
  } vec_t;
  vec_t v[9];
  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .baud_set(baud_set), .uart_rx(uart_rx),
    .Data(Data), .rx_done(rx_done), .frame_error(frame_error), .rx_busy(rx_busy)
  );
  always #5 Clk = ~Clk;
  function automatic int bit_cycles(input logic [2:0] b, input int pct);
    int baud;
    baud = b == 3'd1 ? 19200 : b == 3'd2 ? 38400 : b == 3'd3 ? 57600 : b == 3'd4 ? 115200 : 9600;
    return (CLK_FREQ / (baud * 16)) * 16 * (100 + pct) / 100;
  endfunction
  function automatic vec_t mk(input logic [2:0] baud, input logic [2:0] mid, input int pct,
                              input logic [7:0] b, input logic stop, input int gap,
                              input int ed, input int ef, input logic [7:0] exd);
    vec_t r;
    r.baud = baud; r.mid = mid; r.pct = pct; r.b = b; r.stop = stop; r.gap = gap;
    r.exp_done = ed; r.exp_ferr = ef; r.exp_data = exd;
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    if (n > 0) #1;
  endtask
  task automatic send(input logic [7:0] b, input int bc, input logic stop,
                      input int spike_bit, input logic [2:0] mid_baud);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      if (i == 5) baud_set = mid_baud;
      if (spike_bit >= 0 && i == spike_bit + 1) begin
        cyc(bc / 2 - 1);
        uart_rx = ~f[i];
        cyc(bc / 16);
        uart_rx = f[i];
        cyc(bc - bc / 2 + 1 - bc / 16);
      end else cyc(bc);
    end
    uart_rx = 1'b1;
  endtask
  task automatic check_frame(input string name, input int ed, input int ef, input logic [7:0] exd);
    check({name, "_done"}, done_cnt - d0, ed);
    check({name, "_ferr"}, ferr_cnt - f0, ef);
    check({name, "_data"}, Data, exd);
    check({name, "_busy"}, rx_busy, 0);
  endtask
  always @(negedge Clk) begin
    if (rx_done) done_cnt++;
    if (frame_error) ferr_cnt++;
    if (rx_done || frame_error || prev_strobe)
      check("strobe_excl", {rx_done & frame_error, prev_strobe & (rx_done | frame_error)}, 0);
    prev_strobe = rx_done | frame_error;
  end
  initial begin
    v[0] = mk(3'd4, 3'd0,  0, 8'h55, 1'b1,   0, 1, 0, 8'h55);
    v[1] = mk(3'd4, 3'd4,  0, 8'hA3, 1'b1, 100, 1, 0, 8'hA3);
    v[2] = mk(3'd0, 3'd0,  3, 8'hC4, 1'b1, 200, 1, 0, 8'hC4);
    v[3] = mk(3'd0, 3'd0, -3, 8'h3B, 1'b1, 200, 1, 0, 8'h3B);
    v[4] = mk(3'd4, 3'd4,  0, 8'h0F, 1'b0, 100, 0, 1, 8'h3B);
    v[5] = mk(3'd1, 3'd1,  0, 8'h81, 1'b1, 100, 1, 0, 8'h81);
    v[6] = mk(3'd2, 3'd2,  0, 8'h7E, 1'b1, 100, 1, 0, 8'h7E);
    v[7] = mk(3'd3, 3'd3,  0, 8'h00, 1'b1, 100, 1, 0, 8'h00);
    v[8] = mk(3'd7, 3'd4,  0, 8'hE1, 1'b1, 200, 1, 0, 8'hE1);
    cyc(3);
    check("rst_data", Data, 0);
    check("rst_done", rx_done, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_busy", rx_busy, 0);
    Reset_n = 1'b1;
    cyc(20);
    for (int i = 0; i < 9; i++) begin
      d0 = done_cnt;
      f0 = ferr_cnt;
      baud_set = v[i].baud;
      send(v[i].b, bit_cycles(v[i].baud, v[i].pct), v[i].stop, -1, v[i].mid);
      cyc(v[i].gap);
      check_frame($sformatf("v%0d", i), v[i].exp_done, v[i].exp_ferr, v[i].exp_data);
    end
    // short low pulse: start bit rejected at its mid-point vote
    d0 = done_cnt;
    f0 = ferr_cnt;
    baud_set = 3'd4;
    uart_rx = 1'b0;
    cyc(20);
    uart_rx = 1'b1;
    cyc(10);
    check("glitch_busy_hi", rx_busy, 1);
    cyc(40);
    check("glitch_busy_lo", rx_busy, 0);
    cyc(100);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    // one-sample spike in data bit 3
    d0 = done_cnt;
    f0 = ferr_cnt;
    send(8'hFF, bit_cycles(3'd4, 0), 1'b1, -1, 3'd4);
    cyc(100);
    d0 = done_cnt;
    send(8'h00, bit_cycles(3'd4, 0), 1'b1, 3, 3'd4);
    cyc(100);
    check_frame("spike", 1, 0, 8'h00);
    // reset during data bit 5
    d0 = done_cnt;
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    cyc(80);
    for (int i = 0; i < 5; i++) begin
      uart_rx = i[0] ? 1'b1 : 1'b0;
      cyc(80);
    end
    uart_rx = 1'b0;
    cyc(40);
    Reset_n = 1'b0;
    cyc(2);
    check("mrst_data", Data, 0);
    check("mrst_done", rx_done, 0);
    check("mrst_ferr", frame_error, 0);
    check("mrst_busy", rx_busy, 0);
    uart_rx = 1'b1;
    cyc(2);
    Reset_n = 1'b1;
    cyc(200);
    check("mrst_nostrobe", done_cnt - d0, 0);
    check("mrst_noferr", ferr_cnt - f0, 0);
    send(8'h96, bit_cycles(3'd4, 0), 1'b1, -1, 3'd4);
    cyc(100);
    check_frame("after_rst", 1, 0, 8'h96);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
